if_fetch_queue: RTL
===================

Name: if_fetch_queue

Overview:
- Dual-issue fetch stage with a decoupling fetch queue, sitting directly upstream of the decode stage.
- Each request fetches an instruction pair from instruction memory: addresses pc and pc+1.
- Pairs are buffered in a small FIFO, then presented as instr_1/instr_2 with pc_out_1/pc_out_2 to decode.
- Absorbs decode stalls without losing fetched data; handles branch/jump redirects by flushing.

Parameters:
- RESET_PC, 16'h0000, fetch PC loaded on reset.
- QDEPTH, 4, queue capacity in instruction pairs (power of 2, ≥2).
- NOP_INSTR, 16'h0000, encoding driven on instr outputs when invalid.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  16  address of first instruction of the pair (= fetch_pc).
- imem_rdata_1  in  16  instruction at the requested address; valid exactly 1 cycle after imem_req.
- imem_rdata_2  in  16  instruction at requested address+1; same timing.
- stall  in  1  downstream cannot accept; hold outputs.
- redirect  in  1  control-flow redirect (taken branch/jump/mispredict).
- redirect_pc  in  16  new fetch target.
- instr_1  out  16  first instruction to decode.
- instr_2  out  16  second instruction to decode.
- pc_out_1  out  16  PC of instr_1.
- pc_out_2  out  16  PC of instr_2 (= pc_out_1+1 mod 2^16).
- valid_out  out  1  output pair is real (not bubble).
- q_count  out  3  current queue occupancy (0..QDEPTH).

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC; queue empty (head=tail=count=0); inflight=0; instr_1=instr_2=NOP_INSTR; pc_out_1=pc_out_2=0; valid_out=0.
- imem_req is combinational: 1 when !rst && !redirect && (count+inflight < QDEPTH); imem_addr=fetch_pc always.
- On issue: fetch_pc <= fetch_pc+2 (16-bit wrap, FFFE→0000, FFFF→0001); inflight <= 1 with inflight_pc <= fetch_pc. Otherwise inflight <= 0.
- Response: in the cycle where inflight=1, {imem_rdata_1, imem_rdata_2, inflight_pc} is pushed at the tail at the end of that cycle. inflight_pc+1 is computed with wrap.
- Pop: at an edge with !stall:
  - count>0: head entry → output regs, valid_out <= 1.
  - count==0: instr_1/2 <= NOP_INSTR, valid_out <= 0, pc outputs hold.
- Pop uses count before the same-cycle push; there is no empty-queue bypass.
- stall=1: output regs and valid_out hold; push still allowed.
- Simultaneous push and pop: count unchanged; pointers wrap modulo QDEPTH.
- Admission counts inflight and ignores same-cycle pops, so the queue never overflows.
- Push never blocks.
- Redirect (priority over stall and everything else except rst):
  - queue flushed, count=0;
  - inflight <= 0, so the response arriving next cycle is discarded;
  - fetch_pc <= redirect_pc;
  - outputs <= NOP_INSTR, valid_out <= 0.
- Redirect-to-output timing, redirect in cycle T:
  - T+1: imem_req=1, imem_addr=redirect_pc.
  - T+2: data returned, pushed at end of T+2.
  - T+3: count=1, popped at end of T+3.
  - T+4: valid_out=1, pc_out_1=redirect_pc.
- Odd redirect_pc is legal; the pair is (pc, pc+1).
- Steady state with stall=0: one pair per cycle, count settles ≤1.
- Full queue: count=QDEPTH with stall=1 → imem_req=0, fetch_pc frozen.

Test Plan:
- Reset release, imem returns mem[a]=a: req at 0,2,4; first valid_out at cycle 3 after reset release with pc_out_1=0, instr_1=0, instr_2=1; then consecutive pairs every cycle.
- stall held 10 cycles from steady state → q_count reaches 4, imem_req=0, outputs frozen. Release stall → pairs in strict order, no gaps, no duplicates.
- redirect to 16'h0040 while inflight=1 and queue holds 2 pairs → discarded data never appears; valid_out=0 for T+1..T+3; pc_out_1=0040 at T+4.
- redirect asserted together with stall=1 → flush still occurs, valid_out=0 next cycle.
- redirect_pc=16'hFFFE → pairs (FFFE,FFFF) then (0000,0001). redirect_pc=16'hFFFF → pc_out_2=0000.
- rst asserted mid-stream with full queue → next cycle q_count=0, valid_out=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Dual-issue fetch stage: issues pc/pc+1 pair fetches and buffers returned pairs in a small queue ahead of decode.
// Admission counts the in-flight fetch so the queue cannot overflow; a redirect flushes everything, including the pending response.
module if_fetch_queue #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          QDEPTH    = 4,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata_1,
  input  logic [15:0] imem_rdata_2,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_1,
  output logic [15:0] instr_2,
  output logic [15:0] pc_out_1,
  output logic [15:0] pc_out_2,
  output logic        valid_out,
  output logic [2:0]  q_count
);

  localparam int         PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [3:0] QD = 4'(QDEPTH);

  logic [15:0]   fetch_pc;
  logic [15:0]   inflight_pc;
  logic          inflight;
  logic [15:0]   q_i1 [QDEPTH];
  logic [15:0]   q_i2 [QDEPTH];
  logic [15:0]   q_pc [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [2:0]    count;
  logic [3:0]    occ;
  logic          push;
  logic          pop;

  // The pending response reserves a slot, which is what makes the push unconditional.
  assign occ       = {1'b0, count} + {3'b000, inflight};
  assign imem_req  = !rst && !redirect && (occ < QD);
  assign imem_addr = fetch_pc;
  assign q_count   = count;
  assign push      = inflight;
  assign pop       = !stall && (count != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 16'h0000;
      head        <= '0;
      tail        <= '0;
      count       <= 3'd0;
      instr_1     <= NOP_INSTR;
      instr_2     <= NOP_INSTR;
      pc_out_1    <= 16'h0000;
      pc_out_2    <= 16'h0000;
      valid_out   <= 1'b0;
    end else if (redirect) begin
      fetch_pc  <= redirect_pc;
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= 3'd0;
      instr_1   <= NOP_INSTR;
      instr_2   <= NOP_INSTR;
      valid_out <= 1'b0;
    end else begin
      if (imem_req) begin
        fetch_pc    <= fetch_pc + 16'd2;
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
      end else begin
        inflight <= 1'b0;
      end

      if (push) begin
        q_i1[tail] <= imem_rdata_1;
        q_i2[tail] <= imem_rdata_2;
        q_pc[tail] <= inflight_pc;
        tail       <= tail + 1'b1;
      end

      // Pop looks only at the pre-push count: no bypass from an empty queue.
      if (pop) begin
        instr_1   <= q_i1[head];
        instr_2   <= q_i2[head];
        pc_out_1  <= q_pc[head];
        pc_out_2  <= q_pc[head] + 16'd1;
        head      <= head + 1'b1;
        valid_out <= 1'b1;
      end else if (!stall) begin
        instr_1   <= NOP_INSTR;
        instr_2   <= NOP_INSTR;
        valid_out <= 1'b0;
      end

      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

endmodule
